xfiles_dana_top: RTL and testbench

- Two-core accelerator front end: an X-FILES arbiter with per-core ASID units and a shared 4-entry transaction table, plus a simplified in-order compute engine.
- Each core issues RoCC-style commands to set its ASID, open a transaction, stream input words, and read back output words.
- Compute engine implements network nnid 0 as a loopback: output[i] = input[i].
- Sits between the host cores' accelerator ports and the (future) full neural-network datapath.

---
 rtl/xfiles_pkg.sv | 44 ++++
 rtl/xfiles_asid_unit.sv | 31 +++
 rtl/xfiles_dana_top.sv | 265 ++++++++++++++++++++++++++
 tb/tb_xfiles_dana_top.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xfiles_pkg.sv
// Shared definitions for the X-FILES/DANA front end: sizes, funct bit
// positions, the transaction-table entry layout and the engine states.
package xfiles_pkg;

  localparam int unsigned NUM_CORES     = 2;
  localparam int unsigned TABLE_ENTRIES = 4;
  localparam int unsigned MAX_WORDS     = 32;
  localparam int unsigned DATA_W        = 32;
  localparam int unsigned ASID_W        = 16;
  localparam int unsigned TID_W         = 16;
  localparam int unsigned NNID_W        = 32;
  localparam int unsigned IDX_W         = $clog2(TABLE_ENTRIES);
  localparam int unsigned PTR_W         = $clog2(MAX_WORDS);
  localparam int unsigned CNT_W         = $clog2(MAX_WORDS + 1);

  // cmd_bits_inst_funct bit positions
  localparam int unsigned FUNCT_WRITE = 0;
  localparam int unsigned FUNCT_NEW   = 1;
  localparam int unsigned FUNCT_LAST  = 2;

  localparam logic [63:0] ERR_DATA = '1;

  // reserved: accepting input words; waiting: input complete, queued for
  // the engine; done: output buffer ready to be read back.
  typedef struct packed {
    logic              valid;
    logic              reserved;
    logic              waiting;
    logic              done;
    logic              owner;
    logic [ASID_W-1:0] asid;
    logic [TID_W-1:0]  tid;
    logic [NNID_W-1:0] nnid;
    logic [CNT_W-1:0]  wcnt;
    logic [CNT_W-1:0]  ridx;
  } entry_t;

  typedef enum logic [1:0] {
    ENG_IDLE = 2'd0,
    ENG_COPY = 2'd1,
    ENG_FIN  = 2'd2
  } eng_state_t;

endpackage

// File: rtl/xfiles_asid_unit.sv
// Per-core ASID register and transaction-ID counter.
// Ports: clk/reset; set_en+set_asid load a new ASID and clear the counter;
// tid_inc advances the counter (16-bit wrap); valid/asid/tid are the state.
module xfiles_asid_unit
  import xfiles_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en,
  input  logic [ASID_W-1:0] set_asid,
  input  logic              tid_inc,
  output logic              valid,
  output logic [ASID_W-1:0] asid,
  output logic [TID_W-1:0]  tid
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      asid  <= '0;
      tid   <= '0;
    end else if (set_en) begin
      valid <= 1'b1;
      asid  <= set_asid;
      tid   <= '0;
    end else if (tid_inc) begin
      tid <= tid + TID_W'(1);
    end
  end

endmodule

// File: rtl/xfiles_dana_top.sv
// Two-core X-FILES arbiter with a shared 4-entry transaction table and a
// loopback compute engine (nnid 0: output[i] = input[i]).
// Ports per core n (io_arbiter_<n>_*): cmd handshake and RoCC fields in,
// one-cycle resp pulse (rd echo + 64-bit data) out, busy, s (supervisor) in,
// interrupt (one-cycle error pulse) out. clk, synchronous active-high reset.
module xfiles_dana_top
  import xfiles_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic        io_arbiter_0_cmd_ready,
  input  logic        io_arbiter_0_cmd_valid,
  input  logic [6:0]  io_arbiter_0_cmd_bits_inst_funct,
  input  logic [4:0]  io_arbiter_0_cmd_bits_inst_rs2,
  input  logic [4:0]  io_arbiter_0_cmd_bits_inst_rs1,
  input  logic [4:0]  io_arbiter_0_cmd_bits_inst_rd,
  input  logic        io_arbiter_0_cmd_bits_inst_xd,
  input  logic        io_arbiter_0_cmd_bits_inst_xs1,
  input  logic        io_arbiter_0_cmd_bits_inst_xs2,
  input  logic [6:0]  io_arbiter_0_cmd_bits_inst_opcode,
  input  logic [63:0] io_arbiter_0_cmd_bits_rs1,
  input  logic [63:0] io_arbiter_0_cmd_bits_rs2,
  input  logic        io_arbiter_0_resp_ready,
  output logic        io_arbiter_0_resp_valid,
  output logic [4:0]  io_arbiter_0_resp_bits_rd,
  output logic [63:0] io_arbiter_0_resp_bits_data,
  output logic        io_arbiter_0_busy,
  input  logic        io_arbiter_0_s,
  output logic        io_arbiter_0_interrupt,
  output logic        io_arbiter_1_cmd_ready,
  input  logic        io_arbiter_1_cmd_valid,
  input  logic [6:0]  io_arbiter_1_cmd_bits_inst_funct,
  input  logic [4:0]  io_arbiter_1_cmd_bits_inst_rs2,
  input  logic [4:0]  io_arbiter_1_cmd_bits_inst_rs1,
  input  logic [4:0]  io_arbiter_1_cmd_bits_inst_rd,
  input  logic        io_arbiter_1_cmd_bits_inst_xd,
  input  logic        io_arbiter_1_cmd_bits_inst_xs1,
  input  logic        io_arbiter_1_cmd_bits_inst_xs2,
  input  logic [6:0]  io_arbiter_1_cmd_bits_inst_opcode,
  input  logic [63:0] io_arbiter_1_cmd_bits_rs1,
  input  logic [63:0] io_arbiter_1_cmd_bits_rs2,
  input  logic        io_arbiter_1_resp_ready,
  output logic        io_arbiter_1_resp_valid,
  output logic [4:0]  io_arbiter_1_resp_bits_rd,
  output logic [63:0] io_arbiter_1_resp_bits_data,
  output logic        io_arbiter_1_busy,
  input  logic        io_arbiter_1_s,
  output logic        io_arbiter_1_interrupt
);

  entry_t            tbl [TABLE_ENTRIES];
  logic [DATA_W-1:0] in_buf  [TABLE_ENTRIES][MAX_WORDS];
  logic [DATA_W-1:0] out_buf [TABLE_ENTRIES][MAX_WORDS];

  // Fixed priority: core1 is only ready when core0 is not requesting, so at
  // most one command is accepted per cycle and csel names its core.
  logic acc0, acc1, acc, csel;
  assign io_arbiter_0_cmd_ready = !reset;
  assign io_arbiter_1_cmd_ready = !reset && !io_arbiter_0_cmd_valid;
  assign acc0 = io_arbiter_0_cmd_valid && io_arbiter_0_cmd_ready;
  assign acc1 = io_arbiter_1_cmd_valid && io_arbiter_1_cmd_ready;
  assign acc  = acc0 || acc1;
  assign csel = acc1;

  logic [6:0]  c_funct;
  logic [63:0] c_rs1, c_rs2;
  logic [4:0]  c_rd;
  logic        c_s;
  assign c_funct = csel ? io_arbiter_1_cmd_bits_inst_funct : io_arbiter_0_cmd_bits_inst_funct;
  assign c_rs1   = csel ? io_arbiter_1_cmd_bits_rs1 : io_arbiter_0_cmd_bits_rs1;
  assign c_rs2   = csel ? io_arbiter_1_cmd_bits_rs2 : io_arbiter_0_cmd_bits_rs2;
  assign c_rd    = csel ? io_arbiter_1_cmd_bits_inst_rd : io_arbiter_0_cmd_bits_inst_rd;
  assign c_s     = csel ? io_arbiter_1_s : io_arbiter_0_s;

  logic              do_alloc, do_write, do_read, err, resp_fire;
  logic [63:0]       resp_data;
  logic              av [2];
  logic [ASID_W-1:0] aa [2];
  logic [TID_W-1:0]  at [2];

  xfiles_asid_unit u_asid0 (
    .clk(clk), .reset(reset),
    .set_en(acc0 && io_arbiter_0_s), .set_asid(io_arbiter_0_cmd_bits_rs1[ASID_W-1:0]),
    .tid_inc(do_alloc && !csel),
    .valid(av[0]), .asid(aa[0]), .tid(at[0])
  );

  xfiles_asid_unit u_asid1 (
    .clk(clk), .reset(reset),
    .set_en(acc1 && io_arbiter_1_s), .set_asid(io_arbiter_1_cmd_bits_rs1[ASID_W-1:0]),
    .tid_inc(do_alloc && csel),
    .valid(av[1]), .asid(aa[1]), .tid(at[1])
  );

  logic              a_valid;
  logic [ASID_W-1:0] a_asid;
  logic [TID_W-1:0]  a_tid;
  assign a_valid = av[csel];
  assign a_asid  = aa[csel];
  assign a_tid   = at[csel];

  // Table search: (asid,tid) hit, lowest free slot, lowest waiting slot.
  logic             hit, free, pick;
  logic [IDX_W-1:0] hit_idx, free_idx, pick_idx;
  logic [1:0]       busy_c;
  always_comb begin
    hit = 1'b0; hit_idx = '0; free = 1'b0; free_idx = '0;
    pick = 1'b0; pick_idx = '0; busy_c = '0;
    for (int i = TABLE_ENTRIES - 1; i >= 0; i--) begin
      if (tbl[i].valid && tbl[i].asid == a_asid && tbl[i].tid == c_rs1[TID_W-1:0]) begin
        hit = 1'b1; hit_idx = IDX_W'(i);
      end
      if (!tbl[i].valid) begin
        free = 1'b1; free_idx = IDX_W'(i);
      end
      if (tbl[i].valid && tbl[i].waiting && !tbl[i].done) begin
        pick = 1'b1; pick_idx = IDX_W'(i);
      end
      if (tbl[i].valid && !tbl[i].done) busy_c[tbl[i].owner] = 1'b1;
    end
  end

  // Command decode for the accepted user command.
  always_comb begin
    do_alloc = 1'b0; do_write = 1'b0; do_read = 1'b0;
    err = 1'b0; resp_fire = 1'b0; resp_data = ERR_DATA;
    if (acc && !c_s) begin
      if (!a_valid) begin
        err = 1'b1;
      end else if (c_funct[FUNCT_NEW] && c_funct[FUNCT_WRITE]) begin
        resp_fire = 1'b1;
        if (free && c_rs2[NNID_W-1:0] == '0) begin
          do_alloc = 1'b1; resp_data = 64'(a_tid);
        end else err = 1'b1;
      end else if (c_funct[FUNCT_WRITE]) begin
        if (hit && tbl[hit_idx].reserved && tbl[hit_idx].wcnt < CNT_W'(MAX_WORDS)) do_write = 1'b1;
        else err = 1'b1;
      end else if (!c_funct[FUNCT_NEW]) begin
        resp_fire = 1'b1;
        if (hit && tbl[hit_idx].done) begin
          do_read = 1'b1;
          resp_data = 64'(out_buf[hit_idx][PTR_W'(tbl[hit_idx].ridx)]);
        end else err = 1'b1;
      end else begin
        err = 1'b1;
      end
    end
  end

  // Engine: state register / next state / outputs.
  eng_state_t       state_q, state_d;
  logic [IDX_W-1:0] eng_sel_q, sel_d, eng_cur;
  logic [PTR_W-1:0] eng_ptr_q, ptr_d, eng_ptr;
  logic             eng_copy, eng_done_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ENG_IDLE; eng_sel_q <= '0; eng_ptr_q <= '0;
    end else begin
      state_q <= state_d; eng_sel_q <= sel_d; eng_ptr_q <= ptr_d;
    end
  end

  // Word 0 is copied on the pick cycle so done lands wcnt+1 cycles after
  // the last write.
  always_comb begin
    state_d = state_q; sel_d = eng_sel_q; ptr_d = eng_ptr_q;
    case (state_q)
      ENG_IDLE: if (pick) begin
        sel_d   = pick_idx;
        ptr_d   = PTR_W'(1);
        state_d = (tbl[pick_idx].wcnt == CNT_W'(1)) ? ENG_FIN : ENG_COPY;
      end
      ENG_COPY: begin
        ptr_d = eng_ptr_q + PTR_W'(1);
        if (CNT_W'(eng_ptr_q) + CNT_W'(1) == tbl[eng_sel_q].wcnt) state_d = ENG_FIN;
      end
      ENG_FIN:  state_d = ENG_IDLE;
      default:  state_d = ENG_IDLE;
    endcase
  end

  always_comb begin
    eng_copy = 1'b0; eng_cur = eng_sel_q; eng_ptr = eng_ptr_q; eng_done_set = 1'b0;
    case (state_q)
      ENG_IDLE: if (pick) begin
        eng_copy = 1'b1; eng_cur = pick_idx; eng_ptr = '0;
      end
      ENG_COPY: eng_copy = 1'b1;
      ENG_FIN:  eng_done_set = 1'b1;
      default:  ;
    endcase
  end

  // Transaction table update; engine and command never touch the same entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TABLE_ENTRIES; i++) tbl[i] <= '0;
    end else begin
      if (eng_done_set) begin
        tbl[eng_sel_q].waiting <= 1'b0;
        tbl[eng_sel_q].done    <= 1'b1;
      end
      if (do_alloc) begin
        tbl[free_idx] <= '{valid: 1'b1, reserved: 1'b1, waiting: 1'b0, done: 1'b0,
                           owner: csel, asid: a_asid, tid: a_tid,
                           nnid: c_rs2[NNID_W-1:0], wcnt: '0, ridx: '0};
      end
      if (do_write) begin
        tbl[hit_idx].wcnt <= tbl[hit_idx].wcnt + CNT_W'(1);
        if (c_funct[FUNCT_LAST]) begin
          tbl[hit_idx].reserved <= 1'b0;
          tbl[hit_idx].waiting  <= 1'b1;
        end
      end
      if (do_read) begin
        if (tbl[hit_idx].ridx + CNT_W'(1) == tbl[hit_idx].wcnt) tbl[hit_idx] <= '0;
        else tbl[hit_idx].ridx <= tbl[hit_idx].ridx + CNT_W'(1);
      end
    end
  end

  // Word buffers hold data only; validity lives in the table.
  always_ff @(posedge clk) begin
    if (do_write) in_buf[hit_idx][PTR_W'(tbl[hit_idx].wcnt)] <= c_rs2[DATA_W-1:0];
    if (eng_copy) out_buf[eng_cur][eng_ptr] <= in_buf[eng_cur][eng_ptr];
  end

  // Registered per-core response, interrupt and busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      io_arbiter_0_resp_valid <= 1'b0; io_arbiter_0_resp_bits_rd <= '0;
      io_arbiter_0_resp_bits_data <= '0; io_arbiter_0_interrupt <= 1'b0;
      io_arbiter_0_busy <= 1'b0;
      io_arbiter_1_resp_valid <= 1'b0; io_arbiter_1_resp_bits_rd <= '0;
      io_arbiter_1_resp_bits_data <= '0; io_arbiter_1_interrupt <= 1'b0;
      io_arbiter_1_busy <= 1'b0;
    end else begin
      io_arbiter_0_resp_valid <= resp_fire && !csel;
      io_arbiter_1_resp_valid <= resp_fire && csel;
      io_arbiter_0_interrupt  <= err && !csel;
      io_arbiter_1_interrupt  <= err && csel;
      if (resp_fire && !csel) begin
        io_arbiter_0_resp_bits_rd <= c_rd; io_arbiter_0_resp_bits_data <= resp_data;
      end
      if (resp_fire && csel) begin
        io_arbiter_1_resp_bits_rd <= c_rd; io_arbiter_1_resp_bits_data <= resp_data;
      end
      io_arbiter_0_busy <= busy_c[0];
      io_arbiter_1_busy <= busy_c[1];
    end
  end

  logic unused_inputs;
  assign unused_inputs = ^{io_arbiter_0_cmd_bits_inst_rs2, io_arbiter_0_cmd_bits_inst_rs1,
                           io_arbiter_0_cmd_bits_inst_xd, io_arbiter_0_cmd_bits_inst_xs1,
                           io_arbiter_0_cmd_bits_inst_xs2, io_arbiter_0_cmd_bits_inst_opcode,
                           io_arbiter_0_resp_ready,
                           io_arbiter_1_cmd_bits_inst_rs2, io_arbiter_1_cmd_bits_inst_rs1,
                           io_arbiter_1_cmd_bits_inst_xd, io_arbiter_1_cmd_bits_inst_xs1,
                           io_arbiter_1_cmd_bits_inst_xs2, io_arbiter_1_cmd_bits_inst_opcode,
                           io_arbiter_1_resp_ready,
                           c_funct[6:3], c_rs1[63:TID_W], c_rs2[63:DATA_W]};

endmodule

// File: tb/tb_xfiles_dana_top.sv
module tb_xfiles_dana_top;
  import xfiles_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        cv [2], ss [2], rdy [2], rv [2], irq [2], bsy [2];
  logic [6:0]  fn [2];
  logic [63:0] r1 [2], r2 [2], rdat [2];
  logic [4:0]  rdi [2], rdo [2];

  int total = 0;
  int bad   = 0;
  localparam logic [63:0] ERR = 64'hFFFF_FFFF_FFFF_FFFF;

  xfiles_dana_top dut (
    .clk(clk), .reset(reset),
    .io_arbiter_0_cmd_ready(rdy[0]), .io_arbiter_0_cmd_valid(cv[0]),
    .io_arbiter_0_cmd_bits_inst_funct(fn[0]), .io_arbiter_0_cmd_bits_inst_rs2(5'd0),
    .io_arbiter_0_cmd_bits_inst_rs1(5'd0), .io_arbiter_0_cmd_bits_inst_rd(rdi[0]),
    .io_arbiter_0_cmd_bits_inst_xd(1'b1), .io_arbiter_0_cmd_bits_inst_xs1(1'b1),
    .io_arbiter_0_cmd_bits_inst_xs2(1'b1), .io_arbiter_0_cmd_bits_inst_opcode(7'h0b),
    .io_arbiter_0_cmd_bits_rs1(r1[0]), .io_arbiter_0_cmd_bits_rs2(r2[0]),
    .io_arbiter_0_resp_ready(1'b1), .io_arbiter_0_resp_valid(rv[0]),
    .io_arbiter_0_resp_bits_rd(rdo[0]), .io_arbiter_0_resp_bits_data(rdat[0]),
    .io_arbiter_0_busy(bsy[0]), .io_arbiter_0_s(ss[0]), .io_arbiter_0_interrupt(irq[0]),
    .io_arbiter_1_cmd_ready(rdy[1]), .io_arbiter_1_cmd_valid(cv[1]),
    .io_arbiter_1_cmd_bits_inst_funct(fn[1]), .io_arbiter_1_cmd_bits_inst_rs2(5'd0),
    .io_arbiter_1_cmd_bits_inst_rs1(5'd0), .io_arbiter_1_cmd_bits_inst_rd(rdi[1]),
    .io_arbiter_1_cmd_bits_inst_xd(1'b1), .io_arbiter_1_cmd_bits_inst_xs1(1'b1),
    .io_arbiter_1_cmd_bits_inst_xs2(1'b1), .io_arbiter_1_cmd_bits_inst_opcode(7'h0b),
    .io_arbiter_1_cmd_bits_rs1(r1[1]), .io_arbiter_1_cmd_bits_rs2(r2[1]),
    .io_arbiter_1_resp_ready(1'b1), .io_arbiter_1_resp_valid(rv[1]),
    .io_arbiter_1_resp_bits_rd(rdo[1]), .io_arbiter_1_resp_bits_data(rdat[1]),
    .io_arbiter_1_busy(bsy[1]), .io_arbiter_1_s(ss[1]), .io_arbiter_1_interrupt(irq[1])
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One command on core c, accepted on the next rising edge; response and
  // interrupt are sampled just after that edge.
  task automatic cmd(input int c, input logic s, input logic [6:0] f,
                     input logic [63:0] a, input logic [63:0] b,
                     input logic exp_v, input logic chk_d, input logic [63:0] exp_d,
                     input logic exp_i, input string nm);
    logic [4:0] rdv;
    rdv = 5'($urandom);
    @(negedge clk);
    cv[c] = 1'b1; ss[c] = s; fn[c] = f; r1[c] = a; r2[c] = b; rdi[c] = rdv;
    #1 chk({nm, " ready"}, 64'(rdy[c]), 64'd1);
    @(posedge clk);
    #1 cv[c] = 1'b0;
    chk({nm, " resp_valid"}, 64'(rv[c]), 64'(exp_v));
    chk({nm, " interrupt"}, 64'(irq[c]), 64'(exp_i));
    if (exp_v && chk_d) begin
      chk({nm, " data"}, rdat[c], exp_d);
      chk({nm, " rd"}, 64'(rdo[c]), 64'(rdv));
    end
  endtask

  typedef struct packed {
    logic        c;
    logic        s;
    logic [6:0]  f;
    logic [63:0] a;
    logic [63:0] b;
    logic        v;
    logic [63:0] d;
    logic        i;
  } vec_t;
  vec_t vt [7];

  // Reference model for the random phase: per-entry word lists.
  logic [31:0] mw [4][32];
  int          mlen [4], mwr [4], mrd [4], mcore [4];
  logic [15:0] mtid [4];
  logic [15:0] mcnt [2];

  initial begin
    int n, left, e;
    logic [6:0] f;
    for (int c = 0; c < 2; c++) begin
      cv[c] = 0; ss[c] = 0; fn[c] = '0; r1[c] = '0; r2[c] = '0; rdi[c] = '0;
    end

    // Reset state
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      chk("reset cmd_ready", 64'(rdy[c]), 64'd0);
      chk("reset resp_valid", 64'(rv[c]), 64'd0);
      chk("reset resp_data", rdat[c], 64'd0);
      chk("reset resp_rd", 64'(rdo[c]), 64'd0);
      chk("reset interrupt", 64'(irq[c]), 64'd0);
      chk("reset busy", 64'(bsy[c]), 64'd0);
    end
    @(negedge clk) reset = 1'b0;

    // Basic command decode vectors
    vt[0] = '{c: 1'b0, s: 1'b1, f: 7'd0, a: 64'h1234, b: 64'd0, v: 1'b0, d: 64'd0, i: 1'b0};
    vt[1] = '{c: 1'b1, s: 1'b0, f: 7'd3, a: 64'd0, b: 64'd0, v: 1'b0, d: 64'd0, i: 1'b1};
    vt[2] = '{c: 1'b0, s: 1'b0, f: 7'd3, a: 64'hFFFF_0000_0000_0000, b: 64'hDEAD_BEEF_0000_0000,
              v: 1'b1, d: 64'd0, i: 1'b0};
    vt[3] = '{c: 1'b0, s: 1'b0, f: 7'd0, a: 64'd0, b: 64'd0, v: 1'b1, d: ERR, i: 1'b1};
    vt[4] = '{c: 1'b0, s: 1'b0, f: 7'd1, a: 64'd5, b: 64'd0, v: 1'b0, d: 64'd0, i: 1'b1};
    vt[5] = '{c: 1'b0, s: 1'b0, f: 7'd1, a: 64'hABCD_0000_0000_0000, b: 64'h1111_1111_0000_0000,
              v: 1'b0, d: 64'd0, i: 1'b0};
    vt[6] = '{c: 1'b0, s: 1'b0, f: 7'd0, a: 64'd0, b: 64'd0, v: 1'b1, d: ERR, i: 1'b1};
    for (int k = 0; k < 7; k++)
      cmd(int'(vt[k].c), vt[k].s, vt[k].f, vt[k].a, vt[k].b, vt[k].v, 1'b1, vt[k].d, vt[k].i,
          $sformatf("vec%0d", k));

    // 30-word loopback on core0 tid 0 (word 0 written above)
    for (int i = 1; i < 30; i++) begin
      if (i == 29) chk("busy0 before last", 64'(bsy[0]), 64'd1);
      cmd(0, 0, (i == 29) ? 7'd5 : 7'd1, 64'd0, 64'(i * 1024), 0, 0, 64'd0, 0, "write30");
    end
    n = 0;
    while (bsy[0] && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("busy0 drops", 64'(bsy[0]), 64'd0);
    chk("done latency window", 64'(n >= 31 && n <= 32), 64'd1);
    cmd(0, 0, 7'd1, 64'd0, 64'd7, 0, 0, 64'd0, 1, "write after last");
    for (int i = 0; i < 30; i++)
      cmd(0, 0, 7'd0, 64'd0, 64'd0, 1, 1, 64'(i * 1024), 0, "read30");
    cmd(0, 0, 7'd0, 64'd0, 64'd0, 1, 1, ERR, 1, "read after free");

    // Exact done latency with a 3-word transaction (tid 1)
    cmd(0, 0, 7'd3, 64'd0, 64'd0, 1, 1, 64'd1, 0, "alloc tid1");
    cmd(0, 0, 7'd1, 64'd1, 64'h11, 0, 0, 64'd0, 0, "lat w0");
    cmd(0, 0, 7'd1, 64'd1, 64'h22, 0, 0, 64'd0, 0, "lat w1");
    cmd(0, 0, 7'd5, 64'd1, 64'h33, 0, 0, 64'd0, 0, "lat w2 last");
    repeat (3) @(posedge clk);
    cmd(0, 0, 7'd0, 64'd1, 64'd0, 1, 1, ERR, 1, "read one cycle early");
    cmd(0, 0, 7'd1, 64'd1, 64'h44, 0, 0, 64'd0, 1, "write after done");
    cmd(0, 0, 7'd0, 64'd1, 64'd0, 1, 1, 64'h11, 0, "lat r0");
    cmd(0, 0, 7'd0, 64'd1, 64'd0, 1, 1, 64'h22, 0, "lat r1");
    cmd(0, 0, 7'd0, 64'd1, 64'd0, 1, 1, 64'h33, 0, "lat r2");

    // Core1: fill table, bad nnid, overflow, table full
    cmd(1, 1, 7'd0, 64'h55, 64'd0, 0, 0, 64'd0, 0, "set asid1");
    for (int i = 0; i < 3; i++)
      cmd(1, 0, 7'd3, 64'd0, 64'd0, 1, 1, 64'(i), 0, "fill alloc");
    cmd(1, 0, 7'd3, 64'd0, 64'd9, 1, 1, ERR, 1, "nnid nonzero");
    cmd(1, 0, 7'd3, 64'd0, 64'd0, 1, 0, 64'd0, 0, "fill alloc 4");
    for (int i = 0; i < 32; i++)
      cmd(1, 0, 7'd1, 64'd0, 64'(i), 0, 0, 64'd0, 0, "fill 32 words");
    cmd(1, 0, 7'd1, 64'd0, 64'd99, 0, 0, 64'd0, 1, "write beyond max");
    cmd(1, 0, 7'd3, 64'd0, 64'd0, 1, 1, ERR, 1, "table full");
    @(posedge clk); #1;
    chk("busy1 with entries", 64'(bsy[1]), 64'd1);

    // Reset mid-operation
    @(negedge clk) reset = 1'b1;
    #1;
    chk("ready0 in reset", 64'(rdy[0]), 64'd0);
    chk("ready1 in reset", 64'(rdy[1]), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    chk("busy0 after reset", 64'(bsy[0]), 64'd0);
    chk("busy1 after reset", 64'(bsy[1]), 64'd0);
    cmd(1, 0, 7'd3, 64'd0, 64'd0, 0, 0, 64'd0, 1, "asid cleared by reset");

    // Simultaneous requests: core0 wins, core1 follows next cycle
    @(negedge clk);
    cv[0] = 1; ss[0] = 1; fn[0] = 7'd0; r1[0] = 64'h0A0A;
    cv[1] = 1; ss[1] = 1; fn[1] = 7'd0; r1[1] = 64'h0B0B;
    #1;
    chk("arb ready0", 64'(rdy[0]), 64'd1);
    chk("arb ready1 blocked", 64'(rdy[1]), 64'd0);
    @(posedge clk);
    #1 cv[0] = 0;
    #1 chk("arb ready1 next", 64'(rdy[1]), 64'd1);
    @(posedge clk);
    #1 cv[1] = 0;
    cmd(1, 0, 7'd0, 64'h7777, 64'd0, 1, 1, ERR, 1, "core1 asid probe");
    cmd(0, 0, 7'd0, 64'h7777, 64'd0, 1, 1, ERR, 1, "core0 asid probe");

    // Randomized transactions against the model
    mcnt[0] = 0; mcnt[1] = 0;
    for (int rnd = 0; rnd < 3; rnd++) begin
      for (int k = 0; k < 4; k++) begin
        mcore[k] = int'($urandom % 2);
        mlen[k]  = int'($urandom_range(1, 32));
        mwr[k] = 0; mrd[k] = 0;
        for (int w = 0; w < 32; w++) mw[k][w] = $urandom;
        cmd(mcore[k], 0, 7'd3, {32'($urandom), 32'd0}, {32'($urandom), 32'd0},
            1, 1, 64'(mcnt[mcore[k]]), 0, "rand alloc");
        mtid[k] = mcnt[mcore[k]];
        mcnt[mcore[k]]++;
      end
      left = mlen[0] + mlen[1] + mlen[2] + mlen[3];
      while (left > 0) begin
        e = int'($urandom % 4);
        if (mwr[e] < mlen[e]) begin
          if ($urandom % 8 == 0) begin
            cmd(mcore[e], 0, 7'd1, 64'(mtid[e] + 16'h100), 64'd0, 0, 0, 64'd0, 1, "rand miss write");
          end else begin
            f = (mwr[e] + 1 == mlen[e]) ? 7'd5 : 7'd1;
            cmd(mcore[e], 0, f, {32'($urandom), 16'($urandom), mtid[e]},
                {32'($urandom), mw[e][mwr[e]]}, 0, 0, 64'd0, 0, "rand write");
            mwr[e]++; left--;
          end
        end
      end
      repeat (150) @(posedge clk);
      #1;
      chk("rand busy0 idle", 64'(bsy[0]), 64'd0);
      chk("rand busy1 idle", 64'(bsy[1]), 64'd0);
      left = mlen[0] + mlen[1] + mlen[2] + mlen[3];
      while (left > 0) begin
        e = int'($urandom % 4);
        if (mrd[e] < mlen[e]) begin
          if ($urandom % 8 == 0) begin
            cmd(mcore[e], 0, 7'd0, 64'(mtid[e] + 16'h100), 64'd0, 1, 1, ERR, 1, "rand miss read");
          end else begin
            cmd(mcore[e], 0, 7'd0, {48'($urandom), mtid[e]}, 64'($urandom),
                1, 1, {32'd0, mw[e][mrd[e]]}, 0, "rand read");
            mrd[e]++; left--;
          end
        end
      end
      cmd(mcore[0], 0, 7'd0, 64'(mtid[0]), 64'd0, 1, 1, ERR, 1, "rand read freed");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
